serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 84 ++++++++
 tb/tb_serial_frame_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/even-parity/stop deserializer feeding a 2-entry output FIFO
module serial_frame_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              si,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              perr,
    output logic              ferr,
    output logic              ovr,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t            state;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] sh;
    logic              par_ok;
    logic [DATA_W-1:0] mem [2];
    logic              wp, rp;
    logic [1:0]        count;
    logic              push, pop, accept;
    assign push       = state == STOP && par_ok && !si;
    assign pop        = dout_valid && dout_ready;
    assign accept     = push && (count != 2'd2 || pop);
    assign dout       = mem[rp];
    assign dout_valid = count != 2'd0;
    assign busy       = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            par_ok <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            perr <= 1'b0;
            ferr <= 1'b0;
            case (state)
                IDLE: if (si) begin
                    state <= DATA;
                    cnt   <= '0;
                end
                DATA: begin
                    sh    <= DATA_W'({sh, si});
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'(DATA_W - 1) ? PARITY : DATA;
                end
                PARITY: begin
                    par_ok <= (^sh) == si;
                    state  <= STOP;
                end
                STOP: begin
                    perr  <= !par_ok;
                    ferr  <= si;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // a same-cycle pop frees a slot, so a full FIFO still accepts the push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
            ovr    <= 1'b0;
        end else begin
            if (accept) begin
                mem[wp] <= sh;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + {1'b0, accept} - {1'b0, pop};
            if (push && !accept) ovr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed and randomized checks against a frame-level queue model
module tb_serial_frame_rx;
    logic       clk = 1'b0, rst, si, dout_ready;
    logic [3:0] dout;
    logic       dout_valid, perr, ferr, ovr, busy;
    int         checks = 0, failures = 0;
    logic [3:0] q[$];
    logic       m_perr, m_ferr, m_ovr;

    always #5 clk = ~clk;

    serial_frame_rx #(.DATA_W(4)) dut (
        .clk(clk), .rst(rst), .si(si), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .perr(perr), .ferr(ferr), .ovr(ovr), .busy(busy)
    );

    function automatic logic pick(input int r);
        return r == 2 ? 1'($urandom % 2) : r[0];
    endfunction

    // drives one bit, then updates the model with what the edge must have done
    task automatic tick(input logic s, input logic r, input logic fend, input logic bp, input logic bs, input logic [3:0] d);
        si = s;
        dout_ready = r;
        @(posedge clk);
        if (r && q.size() > 0) void'(q.pop_front());
        m_perr = fend && bp;
        m_ferr = fend && bs;
        if (fend && !bp && !bs) begin
            if (q.size() < 2) q.push_back(d);
            else m_ovr = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic frame(input logic [3:0] d, input logic bp, input logic bs, input int r, input int lr);
        logic [6:0] bits;
        bits = {1'b1, d, (^d) ^ bp, bs};
        for (int i = 6; i >= 0; i--) tick(bits[i], pick(i == 0 ? lr : r), i == 0, bp, bs, d);
    endtask

    task automatic do_reset();
        rst = 1'b1; si = 1'b0; dout_ready = 1'b0;
        q.delete(); m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; si = 1'b0; dout_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (dout !== 4'd0) begin failures++; $display("FAIL reset_dout got=%0h exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        checks++; if (perr !== 1'b0 || ferr !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", perr, ferr); end
        checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_good();
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL good_busy got=%b exp=1", busy); end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL good_early_valid got=%b exp=0", dout_valid); end
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
        checks++; if (dout_valid !== 1'b1 || dout !== 4'b1011) begin failures++; $display("FAIL good_word got=%b/%b exp=1/1011", dout_valid, dout); end
        checks++; if (perr !== 1'b0 || ferr !== 1'b0) begin failures++; $display("FAIL good_err got=%b%b exp=00", perr, ferr); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL good_one_cycle got=%b exp=0", dout_valid); end
    endtask

    task automatic test_errors();
        do_reset();
        frame(4'b1011, 1'b1, 1'b0, 1, 1);
        checks++; if (perr !== 1'b1 || ferr !== 1'b0 || dout_valid !== 1'b0) begin failures++; $display("FAIL parity got=%b%b%b exp=100", perr, ferr, dout_valid); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL parity_pulse got=%b exp=0", perr); end
        frame(4'b0001, 1'b0, 1'b1, 1, 1);
        checks++; if (ferr !== 1'b1 || perr !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL framing got=%b%b%b%b exp=1000", ferr, perr, dout_valid, busy); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL framing_pulse got=%b exp=0", ferr); end
        frame(4'b0110, 1'b1, 1'b1, 1, 1);
        checks++; if (ferr !== 1'b1 || perr !== 1'b1 || dout_valid !== 1'b0) begin failures++; $display("FAIL both_err got=%b%b%b exp=110", ferr, perr, dout_valid); end
    endtask

    task automatic test_overrun();
        do_reset();
        frame(4'd1, 1'b0, 1'b0, 0, 0);
        frame(4'd2, 1'b0, 1'b0, 0, 0);
        frame(4'd3, 1'b0, 1'b0, 0, 0);
        checks++; if (ovr !== 1'b1 || dout_valid !== 1'b1 || dout !== 4'd1) begin failures++; $display("FAIL ovr_set got=%b%b/%0d exp=11/1", ovr, dout_valid, dout); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (dout !== 4'd2 || ovr !== 1'b1) begin failures++; $display("FAIL ovr_second got=%0d/%b exp=2/1", dout, ovr); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (dout_valid !== 1'b0 || ovr !== 1'b1) begin failures++; $display("FAIL ovr_drain got=%b/%b exp=0/1", dout_valid, ovr); end
    endtask

    task automatic test_full_pop();
        do_reset();
        frame(4'd1, 1'b0, 1'b0, 0, 0);
        frame(4'd2, 1'b0, 1'b0, 0, 0);
        checks++; if (dout !== 4'd1 || ovr !== 1'b0) begin failures++; $display("FAIL fp_head got=%0d/%b exp=1/0", dout, ovr); end
        frame(4'd3, 1'b0, 1'b0, 0, 1);
        checks++; if (dout !== 4'd2 || ovr !== 1'b0) begin failures++; $display("FAIL fp_push_pop got=%0d/%b exp=2/0", dout, ovr); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (dout !== 4'd3 || dout_valid !== 1'b1) begin failures++; $display("FAIL fp_third got=%0d/%b exp=3/1", dout, dout_valid); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL fp_empty got=%b exp=0", dout_valid); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        frame(4'd5, 1'b0, 1'b0, 0, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin failures++; $display("FAIL midrst got=%b%b exp=00", busy, dout_valid); end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        frame(4'b0110, 1'b0, 1'b0, 0, 0);
        checks++; if (dout_valid !== 1'b1 || dout !== 4'b0110) begin failures++; $display("FAIL midrst_next got=%b/%b exp=1/0110", dout_valid, dout); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            if (n % 50 == 0) do_reset();
            repeat ($urandom_range(0, 2)) begin
                tick(1'b0, pick(2), 1'b0, 1'b0, 1'b0, 4'd0);
                checks++; if (dout_valid !== (q.size() > 0) || (q.size() > 0 && dout !== q[0])) begin failures++; $display("FAIL rnd_idle n=%0d got=%b/%0h exp=%0d/%0h", n, dout_valid, dout, q.size(), q.size() > 0 ? q[0] : 4'd0); end
            end
            frame(4'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 2, 2);
            checks++; if (dout_valid !== (q.size() > 0) || (q.size() > 0 && dout !== q[0])) begin failures++; $display("FAIL rnd_word n=%0d got=%b/%0h exp=%0d/%0h", n, dout_valid, dout, q.size(), q.size() > 0 ? q[0] : 4'd0); end
            checks++; if (perr !== m_perr || ferr !== m_ferr || ovr !== m_ovr || busy !== 1'b0) begin failures++; $display("FAIL rnd_flags n=%0d got=%b%b%b%b exp=%b%b%b0", n, perr, ferr, ovr, busy, m_perr, m_ferr, m_ovr); end
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_errors();
        test_overrun();
        test_full_pop();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
